// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package : fetch_pkg
// Purpose : Shared types and constants for the instruction fetch/prefetch unit.
//           fetch_state_t - fetch control FSM states
//           INSTR_BYTES   - PC increment per instruction word
//           FULL_MASK     - byte-enable mask for whole-word reads
//           NOP_INSTR     - canonical NOP (addi x0,x0,0), used as bus filler
// Revision: 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [3:0]  FULL_MASK   = 4'b1111;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : Synchronous FIFO holding {instruction, pc} entries for the
//           prefetch queue. Head entry is presented combinationally.
// Ports   : clk, rst (async active-low)
//           push/wdata  - write an entry (caller guarantees not full)
//           pop         - remove head entry (ignored when empty)
//           flush       - empty the queue; has priority over push/pop
//           rdata       - head entry
//           count/empty - occupancy
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int Width = 64,
  parameter int Depth = 4,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty
);

  localparam logic [CntW-1:0] CNT_ONE = CntW'(1);
  localparam logic [PtrW-1:0] PTR_ONE = PtrW'(1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_pop;

  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  assign count  = cnt;
  assign rdata  = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_prefetch_unit
// Purpose : Instruction fetch with an in-order prefetch queue. Issues
//           sequential word fetches ahead of decode, bounded so that queued
//           plus in-flight words never exceed Depth. Redirects flush the
//           queue and discard responses still in flight for the old path.
// Ports   : clk, rst (async active-low)
//           redirect/redirect_addr         - new fetch target (word aligned)
//           imem_req/imem_addr/imem_ready  - request handshake
//           imem_we_re/imem_mask           - constant read / full word
//           imem_rvalid/imem_rdata         - in-order responses
//           instr_valid/instruction/instr_pc/instr_ready - decode side
// Options : FETCH_PERF_CNT_EN adds perf_fetched (pops) and perf_stall
//           (cycles decode waited on an empty queue) 32-bit counters.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                   DataWidth   = 32,
  parameter int                   AddrWidth   = 32,
  parameter int                   Depth       = 4,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect,
  input  logic [AddrWidth-1:0] redirect_addr,
  input  logic                 instr_ready,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [DataWidth-1:0] imem_rdata,
  output logic                 imem_req,
  output logic [AddrWidth-1:0] imem_addr,
  output logic                 imem_we_re,
  output logic [3:0]           imem_mask,
  output logic                 instr_valid,
  output logic [DataWidth-1:0] instruction,
  output logic [AddrWidth-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  localparam int                   CntW    = $clog2(Depth) + 1;
  localparam int                   EntW    = DataWidth + AddrWidth;
  localparam logic [AddrWidth-1:0] PC_STEP = AddrWidth'(INSTR_BYTES);
  localparam logic [CntW-1:0]      CNT_ONE = CntW'(1);
  localparam logic [CntW:0]        CREDITS = (CntW + 1)'(Depth);

  fetch_state_t state, state_nxt;

  logic [AddrWidth-1:0] fetch_pc;
  logic [AddrWidth-1:0] resp_pc;
  logic [CntW-1:0]      outstanding;
  logic [CntW-1:0]      drop_cnt;
  logic [DataWidth-1:0] hold_instr;
  logic [AddrWidth-1:0] hold_pc;

  logic [CntW-1:0]      q_count;
  logic                 q_empty;
  logic [EntW-1:0]      q_head;

  logic                 redirect_eff;
  logic [AddrWidth-1:0] redirect_pc;
  logic [CntW:0]        credit_sum;
  logic                 accept;
  logic                 rvalid_eff;
  logic                 push;
  logic                 pop;
  logic [CntW-1:0]      resp_left;
  logic                 unused_addr_bits;

  // Redirects are ignored during the single boot cycle.
  assign redirect_eff     = redirect && (state != S_BOOT);
  assign redirect_pc      = {redirect_addr[AddrWidth-1:2], 2'b00};
  assign unused_addr_bits = ^redirect_addr[1:0];

  // Queued plus in-flight words may never exceed Depth, so every response
  // that is pushed is guaranteed a free slot.
  assign credit_sum = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req   = (state == S_RUN) && !redirect && (credit_sum < CREDITS);
  assign imem_addr  = fetch_pc;
  assign imem_we_re = 1'b0;
  assign imem_mask  = FULL_MASK;
  assign accept     = imem_req && imem_ready;

  assign rvalid_eff = imem_rvalid && (state != S_BOOT);
  assign push       = rvalid_eff && (state == S_RUN) && !redirect_eff;
  assign pop        = instr_valid && instr_ready;

  // In-flight requests still owed after this cycle's response; these are
  // the stale words to discard after a redirect.
  assign resp_left  = outstanding - (rvalid_eff ? CNT_ONE : {CntW{1'b0}});

  fetch_fifo #(
    .Width (EntW),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({imem_rdata, resp_pc}),
    .pop   (pop),
    .flush (redirect_eff),
    .rdata (q_head),
    .count (q_count),
    .empty (q_empty)
  );

  // Empty queue shows the last head presented rather than stale storage.
  assign instr_valid = !q_empty;
  assign instruction = q_empty ? hold_instr : q_head[EntW-1:AddrWidth];
  assign instr_pc    = q_empty ? hold_pc    : q_head[AddrWidth-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_BOOT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT: state_nxt = S_RUN;
      S_RUN: begin
        if (redirect_eff && (resp_left != '0)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect_eff) begin
          state_nxt = (resp_left != '0) ? S_DRAIN : S_RUN;
        end else if (drop_cnt == '0) begin
          state_nxt = S_RUN;
        end else if (rvalid_eff && (drop_cnt == CNT_ONE)) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= ResetVector;
      resp_pc     <= ResetVector;
      outstanding <= '0;
      drop_cnt    <= '0;
      hold_instr  <= '0;
      hold_pc     <= '0;
    end else begin
      if (redirect_eff) begin
        // No request is accepted in a redirect cycle (req is gated off).
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        outstanding <= resp_left;
        drop_cnt    <= resp_left;
      end else begin
        if (accept) fetch_pc <= fetch_pc + PC_STEP;
        if (push)   resp_pc  <= resp_pc + PC_STEP;
        case ({accept, rvalid_eff})
          2'b10:   outstanding <= outstanding + CNT_ONE;
          2'b01:   outstanding <= outstanding - CNT_ONE;
          default: outstanding <= outstanding;
        endcase
        if ((state == S_DRAIN) && rvalid_eff && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CNT_ONE;
        end
      end
      if (!q_empty) begin
        hold_instr <= q_head[EntW-1:AddrWidth];
        hold_pc    <= q_head[AddrWidth-1:0];
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop)                         perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule : fetch_prefetch_unit
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction fetch unit with an in-order prefetch queue between instruction memory and decode.
- Issues sequential word fetches ahead of decode with a bounded number of outstanding requests.
- Buffers returned words with their PC; redirects from branch or jalr flush the queue and discard stale in-flight responses.
- Replaces the single-word pass-through fetch; sits between the PC/redirect logic and decode.

Parameters:
- DataWidth, 32, instruction word width.
- AddrWidth, 32, PC and memory address width.
- Depth, 4, prefetch queue entries; power of two, >= 2; also the limit on outstanding requests.
- ResetVector, 32'h0, PC after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- redirect  input  1  branch taken or jalr; replaces PC this cycle.
- redirect_addr  input  AddrWidth  new fetch target; bits [1:0] ignored (forced 0).
- instr_ready  input  1  decode accepts the head entry.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid, in order, latency >= 1.
- imem_rdata  input  DataWidth  response word.
- imem_req  output  1  fetch request.
- imem_addr  output  AddrWidth  fetch address.
- imem_we_re  output  1  always 0 (read).
- imem_mask  output  4  always 4'b1111.
- instr_valid  output  1  head entry valid.
- instruction  output  DataWidth  head word.
- instr_pc  output  AddrWidth  PC of head word.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=ResetVector; queue empty; outstanding=0; drop_cnt=0; state=S_BOOT.
  - imem_req=0, instr_valid=0, instruction=0, instr_pc=0.
- FSM states:
  - S_BOOT: one idle cycle after reset release, then S_RUN.
  - S_RUN: issue enabled.
  - S_DRAIN: issue disabled. Each imem_rvalid is discarded and decrements drop_cnt. Go to S_RUN in the cycle drop_cnt reaches 0.
- Issue (S_RUN only):
  - imem_req=1 when queue_count+outstanding < Depth and redirect=0.
  - imem_addr=fetch_pc.
  - Request accepted when imem_req && imem_ready: fetch_pc += 4 (modulo 2^AddrWidth, wraps silently) and outstanding++.
  - imem_req and imem_addr hold stable until accepted, unless a redirect occurs.
- Response:
  - imem_rvalid in S_RUN pushes {imem_rdata, pc} and decrements outstanding.
  - The stored pc comes from a response-PC register that starts at the issue PC and advances by 4 per response.
  - The credit rule guarantees a push never overflows.
- Output:
  - instr_valid = queue not empty; instruction and instr_pc show the head.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When the queue is empty, instruction and instr_pc hold their last value.
- Redirect (any state except S_BOOT):
  - Next cycle: queue empty; fetch_pc and response-PC = {redirect_addr[AddrWidth-1:2],2'b00}.
  - drop_cnt = outstanding minus any response arriving in the redirect cycle, plus any request accepted in the redirect cycle (none, since req=0).
  - state = S_DRAIN if drop_cnt > 0, else S_RUN.
  - A pop in the redirect cycle is still honoured: decode already consumed it.
- Redirect during S_DRAIN: drop_cnt is recomputed as above; the new target wins.
- Latency:
  - Redirect to first imem_req: 1 cycle when nothing is outstanding.
  - Response to instr_valid: 1 cycle (registered queue).
- Reset asserted mid-transfer abandons all state; responses returning afterwards are not expected.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32-bit count of pops) and perf_stall (32-bit count of cycles with instr_ready=1 && instr_valid=0). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_BOOT, S_RUN, S_DRAIN}.
  - INSTR_BYTES=4.
  - FULL_MASK=4'b1111.
  - NOP_INSTR=32'h00000013 (bench filler).
- Sub-module fetch_fifo: synchronous FIFO with width DataWidth+AddrWidth, depth Depth, a flush input, a count output, and async active-low reset.

Test Plan:
- Reset release, imem_ready=1, fixed 1-cycle response, instr_ready=1 -> first imem_req at 0x0 in cycle 2; instr_pc sequence 0x0,0x4,0x8 on consecutive cycles; no bubbles after fill.
- instr_ready=0 held, Depth=4 -> exactly 4 requests accepted (0x0–0xC), then imem_req=0; queue holds 4 entries; releasing instr_ready resumes fetch at 0x10.
- 2 requests outstanding (0x8, 0xC), redirect to 0x100 -> S_DRAIN with drop_cnt=2; both stale responses discarded; next accepted imem_addr=0x100; first instr_pc=0x100.
- Redirect to 0x203 -> imem_addr=0x200.
- Redirect again while draining (to 0x300) -> only pending stale responses dropped; fetch resumes at 0x300.
- imem_ready toggling 0/1 each cycle -> imem_addr stable while req not accepted; PC order intact.
- fetch_pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000; with FETCH_PERF_CNT_EN, 3 starved cycles -> perf_stall=3.
